// File: rtl/clk_sched.sv
// Divided-clock sequencer: gates clk/2, clk/4, clk/8 on and off only at frame boundaries.
// Optional status counter enabled by defining CLK_SCHED_STATUS_EN (adds run_frames port).
module clk_sched #(
  parameter int SETTLE_FR = 2,
  parameter int STEP_FR   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  output logic       clk_4f,
  output logic       clk_2f,
  output logic       clk_f,
  output logic       ready,
`ifdef CLK_SCHED_STATUS_EN
  output logic [7:0] run_frames,
`endif
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    EN4    = 3'd2,
    EN2    = 3'd3,
    RUN    = 3'd4,
    STOP   = 3'd5
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_FR - 1);
  localparam logic [7:0] STEP_LAST   = 8'(STEP_FR - 1);

  state_t     st, st_nxt;
  logic [2:0] ph, ph_nxt;
  logic       g4, g2, gf;
  logic       g4_nxt, g2_nxt, gf_nxt;
  logic [7:0] fr_cnt, fr_nxt;
  logic       boundary;
  logic       settle_done, step_done;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign ph_nxt      = ph + 3'd1;
  // This edge takes ph from 7 to 0, so any gate change lands on a frame start.
  assign boundary    = (ph == 3'd7);
  assign settle_done = boundary && (fr_cnt == SETTLE_LAST);
  assign step_done   = boundary && (fr_cnt == STEP_LAST);
  assign state       = st;

  always_ff @(posedge clk) begin
    if (!reset) begin
      st     <= IDLE;
      ph     <= 3'd0;
      g4     <= 1'b0;
      g2     <= 1'b0;
      gf     <= 1'b0;
      fr_cnt <= 8'd0;
      clk_4f <= 1'b0;
      clk_2f <= 1'b0;
      clk_f  <= 1'b0;
      ready  <= 1'b0;
    end else begin
      st     <= st_nxt;
      ph     <= ph_nxt;
      g4     <= g4_nxt;
      g2     <= g2_nxt;
      gf     <= gf_nxt;
      fr_cnt <= fr_nxt;
      clk_4f <= g4_nxt & ph_nxt[0];
      clk_2f <= g2_nxt & ph_nxt[1];
      clk_f  <= gf_nxt & ph_nxt[2];
      ready  <= gf_nxt;
    end
  end

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:   if (run) st_nxt = SETTLE;
      SETTLE: begin
        if (settle_done)  st_nxt = run ? EN4 : STOP;
        else if (!run)    st_nxt = STOP;
      end
      EN4: begin
        if (step_done)    st_nxt = run ? EN2 : STOP;
        else if (!run)    st_nxt = STOP;
      end
      EN2: begin
        if (step_done)    st_nxt = run ? RUN : STOP;
        else if (!run)    st_nxt = STOP;
      end
      RUN:    if (!run) st_nxt = STOP;
      STOP:   if (boundary) st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  always_comb begin
    g4_nxt = g4;
    g2_nxt = g2;
    gf_nxt = gf;
    case (st)
      SETTLE: if (settle_done) g4_nxt = 1'b1;
      EN4:    if (step_done)   g2_nxt = 1'b1;
      EN2:    if (step_done)   gf_nxt = 1'b1;
      STOP: begin
        if (boundary) begin
          g4_nxt = 1'b0;
          g2_nxt = 1'b0;
          gf_nxt = 1'b0;
        end
      end
      RUN: ;
      default: begin
        g4_nxt = 1'b0;
        g2_nxt = 1'b0;
        gf_nxt = 1'b0;
      end
    endcase

    fr_nxt = fr_cnt;
    if (st_nxt != st)
      fr_nxt = 8'd0;
    else if (boundary && (st == SETTLE || st == EN4 || st == EN2))
      fr_nxt = fr_cnt + 8'd1;
  end

`ifdef CLK_SCHED_STATUS_EN
  // Completed clk_f periods while running; held at 255 once full.
  always_ff @(posedge clk) begin
    if (!reset)
      run_frames <= 8'd0;
    else if (st_nxt == IDLE && st != IDLE)
      run_frames <= 8'd0;
    else if (st == RUN && boundary && gf)
      run_frames <= sat_inc(run_frames);
  end
`endif

endmodule

// File: doc/clk_sched.md
Name: clk_sched

Overview:
- Controller/sequencer for the divided clocks clk_4f, clk_2f and clk_f, all derived from the base clock clk.
- Runs one free-running 3-bit phase counter and gates each divided clock on/off, only at frame boundaries, so no runt pulses occur.
- Start-up sequence brings the clocks up fastest-first: 4f, then 2f, then f. Stop shuts all three off together. Sits between the system reset/run control and every block clocked by the f/2f/4f domains.

Parameters:
- SETTLE_FR, 2, frame boundaries waited in SETTLE before clk_4f is enabled (range 1..255).
- STEP_FR, 2, frame boundaries between enabling successive clocks (range 1..255).

Ports:
- clk  input  1  base clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset.
- run  input  1  level; 1 = request clocks running, 0 = request stop.
- clk_4f  output  1  clk/2, gated.
- clk_2f  output  1  clk/4, gated.
- clk_f  output  1  clk/8, gated.
- ready  output  1  all three clocks running.
- state  output  3  FSM state: IDLE=0, SETTLE=1, EN4=2, EN2=3, RUN=4, STOP=5.

Behaviour:
- Reset, whenever sampled low (including mid-operation):
  - ph=0, all gates g4/g2/gf=0, clk_4f=clk_2f=clk_f=0, ready=0, state=IDLE, frame counter=0.
  - Clocks fall on that same edge, even mid-pulse.
- Phase counter:
  - ph increments every cycle, wraps 7->0.
  - A frame boundary is an edge where ph goes 7->0.
- Outputs are registers, never combinational, with these invariants every cycle: clk_4f = g4 & ph[0], clk_2f = g2 & ph[1], clk_f = gf & ph[2].
- Gates change only on frame boundaries.
  - Enabling: the first rising output appears at ph=1 (4f), ph=2 (2f) or ph=4 (f).
  - Disabling: the last full high phase completes at ph=7 and the output is low from ph=0.
- Frame counter (8 bit):
  - Cleared on every state entry.
  - Increments at each frame boundary while in SETTLE/EN4/EN2.
- FSM:
  - IDLE: gates 0. run=1 -> SETTLE on the next edge, which may be mid-frame.
  - SETTLE: at the SETTLE_FR-th boundary, set g4 and go to EN4.
  - EN4: at the STEP_FR-th boundary, set g2 and go to EN2.
  - EN2: at the STEP_FR-th boundary, set gf and go to RUN. ready=1 from that same edge.
  - RUN: ready=1. run=0 -> STOP.
  - SETTLE/EN4/EN2 with run=0 -> STOP; partially enabled clocks stay on until the boundary.
  - STOP: at the next boundary clear g4/g2/gf together, set ready=0 and go to IDLE. If STOP is entered exactly on a boundary edge, the following boundary is the one used. run=1 during STOP is ignored; the stop completes, and IDLE restarts on the next edge if run is still 1.
- Simultaneous events:
  - A boundary edge that is also the transition edge performs both the gate change and the state change.
  - run=0 sampled on the enabling boundary edge: the enable still applies, then the FSM enters STOP.

Optional Feature:
- Macro: CLK_SCHED_STATUS_EN.
- Defined:
  - Adds output port run_frames [7:0]: count of completed clk_f periods while in RUN, i.e. boundaries with gf=1.
  - Saturates at 255; cleared on reset and on entry to IDLE.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, then run=1 sampled on edge 1 after release (defaults):
  - state: SETTLE at edge 1, EN4 at edge 16, EN2 at edge 32, RUN at edge 48.
  - First rises: clk_4f at edge 17, clk_2f at edge 34, clk_f at edge 52.
  - ready=1 from edge 48.
- In RUN for 4 frames: clk_4f period 2 cycles, clk_2f period 4, clk_f period 8; all rising together at ph=1/2/4; all low at ph=0.
- run=0 at ph=3 in RUN:
  - STOP next edge; clocks keep toggling through ph=7.
  - At the boundary all three go to 0 together, ready=0, state=IDLE.
  - No pulse shorter than 1 clk cycle on any output.
- run=0 during EN4: clk_4f runs until the next boundary then stops; clk_2f/clk_f never toggle; ready never asserts.
- reset low for 1 cycle while in RUN at ph=5: on that edge all outputs 0 and state=IDLE; with run=1 held, the sequence restarts and reproduces the first scenario's timing.
- With CLK_SCHED_STATUS_EN: after 300 boundaries in RUN, run_frames=255. After stop and return to IDLE, run_frames=0.
